rx_fifo: RTL

Byte receive buffer between the serial receiver and the CPU-facing ACIA register logic. It captures each received byte and its error flag on the receiver's one-cycle strobe, then presents the oldest entry first-word-fall-through to the bus side. It also reports fill level, a threshold flag for interrupt generation and a sticky overrun flag. This lets the CPU service several bytes per interrupt at 115200 baud with a 10 MHz clock.

---
 rtl/rx_fifo.sv | 94 +++++++++
 1 files changed

// File: rtl/rx_fifo.sv
// rx_fifo: byte receive buffer between the serial receiver and the ACIA
// register logic. First-word-fall-through head, fill level, threshold flag
// and a sticky overrun flag. All outputs decode from registered state only.
module rx_fifo #(
   parameter int DEPTH  = 16,
   parameter int THRESH = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          wr_stb,
   input  logic [7:0]    wr_dat,
   input  logic          wr_err,
   input  logic          rd_stb,
   output logic [7:0]    rd_dat,
   output logic          rd_err,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level,
   output logic          thresh_hit,
   output logic          ovr,
   input  logic          ovr_clr
);

   localparam logic [AW:0] LP_ONE    = (AW+1)'(1);
   localparam logic [AW:0] LP_DEPTH  = (AW+1)'(DEPTH);
   localparam logic [AW:0] LP_THRESH = (AW+1)'(THRESH);

   // Entry layout is {err, dat}; contents survive reset and are masked by empty.
   logic [8:0]  r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        r_ovr;

   logic [AW:0] w_level;
   logic        w_empty;
   logic        w_full;
   logic        w_clear;
   logic        w_do_wr;
   logic        w_do_rd;
   logic        w_drop;
   logic [8:0]  w_head;

   // Pointers carry one extra bit so full and empty are distinguishable.
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_empty = (w_level == '0);
   assign w_full  = (w_level == LP_DEPTH);
   assign w_clear = rst | flush;

   // A write into a full buffer still lands when a pop frees the head slot
   // in the same cycle; the slot being overwritten is the one being popped.
   assign w_do_wr = wr_stb & (~w_full | rd_stb);
   assign w_do_rd = rd_stb & ~w_empty;
   assign w_drop  = wr_stb & w_full & ~rd_stb;

   assign w_head = r_mem[r_rd_ptr[AW-1:0]];

   // Store the incoming entry; strobes coinciding with a clear are discarded.
   always_ff @(posedge clk) begin
      if (!w_clear && w_do_wr)
         r_mem[r_wr_ptr[AW-1:0]] <= {wr_err, wr_dat};
   end

   // Advance pointers on accepted writes and pops.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + LP_ONE;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + LP_ONE;
      end
   end

   // Sticky overrun: a dropped write outranks a clear request in the same cycle.
   always_ff @(posedge clk) begin
      if (w_clear)      r_ovr <= 1'b0;
      else if (w_drop)  r_ovr <= 1'b1;
      else if (ovr_clr) r_ovr <= 1'b0;
   end

   // Flag and head decode from registered state.
   always_comb begin
      rd_dat     = w_empty ? 8'h00 : w_head[7:0];
      rd_err     = w_empty ? 1'b0  : w_head[8];
      empty      = w_empty;
      full       = w_full;
      level      = w_level;
      thresh_hit = (w_level >= LP_THRESH);
      ovr        = r_ovr;
   end

endmodule
